// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: shared defaults and width helper for the FIFO write arbiter.
//   N_REQ_DEF   default number of requesters
//   DATA_W_DEF  default word width
//   DEPTH_DEF   default downstream FIFO depth
//   clog2_plus1 width needed to hold the values 0..depth
package fifo_arb_pkg;
    localparam int N_REQ_DEF  = 4;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;

    function automatic int clog2_plus1(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after i_ptr.
//   i_req  request vector
//   i_ptr  highest-priority index this cycle
//   o_gnt  one-hot grant, zero when nothing requests
//   o_idx  index of the winner
//   o_any  at least one request present
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_any
);
    // Scan from the far end back towards i_ptr so the nearest hit is written last.
    always_comb begin
        logic [PTR_W-1:0] w_j;
        w_j   = '0;
        o_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = PTR_W'((int'(i_ptr) + k) % N);
            if (i_req[w_j]) o_idx = w_j;
        end
    end

    assign o_any = |i_req;
    assign o_gnt = o_any ? (N'(1) << o_idx) : '0;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: credit-based round-robin arbiter feeding one syn_fifo write port.
//   clk, rst          clock, synchronous active-low reset
//   req_valid/data    per-requester word offer, requester i at [i*DATA_W +: DATA_W]
//   req_gnt           one-hot acceptance this cycle
//   fifo_write_en/..  registered write to syn_fifo
//   fifo_full         syn_fifo full, used only for the overflow check
//   fifo_read_en/..   consumer read observed to return credits
//   credits           free entries, counting the write still in flight
//   err_ovf, err_udf  sticky overflow / credit-underflow flags
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = clog2_plus1(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_gnt,
    output logic                    fifo_write_en,
    output logic [DATA_W-1:0]       fifo_data_in,
    input  logic                    fifo_full,
    input  logic                    fifo_read_en,
    input  logic                    fifo_empty,
    output logic [CNT_W-1:0]        credits,
    output logic                    err_ovf,
    output logic                    err_udf
);
    localparam int PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0]  r_rr_ptr;
    logic [CNT_W-1:0]  r_credits;
    logic              r_wr_en;
    logic [DATA_W-1:0] r_data;
    logic              r_ovf;
    logic              r_udf;

    logic [N_REQ-1:0]  w_gnt;
    logic [PTR_W-1:0]  w_idx;
    logic              w_any;
    logic              w_accept;
    logic              w_rd_fire;
    logic              w_at_depth;
    logic              w_rd_inc;

    rr_pick #(.N(N_REQ), .PTR_W(PTR_W)) u_pick (
        .i_req (req_valid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_rd_fire  = fifo_read_en && !fifo_empty;
    assign w_at_depth = r_credits == CNT_W'(DEPTH);
    // Grants are suppressed during reset so no word is lost to a dropped write.
    assign w_accept   = rst && w_any && (r_credits != '0);
    // A read at full credit is bogus; it must not push credits past DEPTH.
    assign w_rd_inc   = w_rd_fire && !(w_at_depth && !w_accept);
    assign req_gnt    = w_accept ? w_gnt : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rr_ptr  <= '0;
            r_credits <= CNT_W'(DEPTH);
            r_wr_en   <= 1'b0;
            r_data    <= '0;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
        end else begin
            r_wr_en   <= w_accept;
            r_credits <= r_credits - CNT_W'(w_accept) + CNT_W'(w_rd_inc);
            if (w_accept) begin
                r_data   <= req_data[int'(w_idx)*DATA_W +: DATA_W];
                r_rr_ptr <= (w_idx == PTR_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
            end
            if (w_rd_fire && w_at_depth) r_udf <= 1'b1;
            if (r_wr_en && fifo_full) r_ovf <= 1'b1;
        end
    end

    assign fifo_write_en = r_wr_en;
    assign fifo_data_in  = r_data;
    assign credits       = r_credits;
    assign err_ovf       = r_ovf;
    assign err_udf       = r_udf;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed bench for fifo_wr_arbiter with a queue model of syn_fifo.
module tb_fifo_wr_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_gnt;
    logic        fifo_write_en;
    logic [7:0]  fifo_data_in;
    logic        fifo_full;
    logic        fifo_read_en;
    logic        fifo_empty;
    logic [4:0]  credits;
    logic        err_ovf;
    logic        err_udf;

    logic        ovr_full;
    logic        ovr_nempty;
    int          occ;
    logic [7:0]  q[$];
    logic [7:0]  got[$];
    logic [7:0]  wd[17];
    int          tests;
    int          fails;

    always #5 clk = ~clk;

    fifo_wr_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_gnt       (req_gnt),
        .fifo_write_en (fifo_write_en),
        .fifo_data_in  (fifo_data_in),
        .fifo_full     (fifo_full),
        .fifo_read_en  (fifo_read_en),
        .fifo_empty    (fifo_empty),
        .credits       (credits),
        .err_ovf       (err_ovf),
        .err_udf       (err_udf)
    );

    assign fifo_full  = ovr_full || (occ == 16);
    assign fifo_empty = !ovr_nempty && (occ == 0);

    always @(posedge clk) begin
        if (!rst) begin
            q.delete();
        end else begin
            if (fifo_read_en && !fifo_empty && q.size() > 0) got.push_back(q.pop_front());
            if (fifo_write_en) q.push_back(fifo_data_in);
        end
        occ <= q.size();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0; fails = 0; occ = 0;
        rst = 1'b0; req_valid = 4'hF; req_data = 32'h44332211;
        fifo_read_en = 1'b0; ovr_full = 1'b0; ovr_nempty = 1'b0;
        for (int i = 0; i < 17; i++) wd[i] = 8'($urandom);
        #1;
        check("rst_gnt_comb", req_gnt, 0);
        tick(); tick();
        check("rst_gnt", req_gnt, 0);
        check("rst_wen", fifo_write_en, 0);
        check("rst_data", fifo_data_in, 0);
        check("rst_credits", credits, 16);
        check("rst_ovf", err_ovf, 0);
        check("rst_udf", err_udf, 0);

        rst = 1'b1; req_valid = 4'b0001;
        for (int k = 0; k < 16; k++) begin
            req_data = {24'h0, wd[k]};
            #1;
            check("fill_gnt", req_gnt, 4'b0001);
            check("fill_credits", credits, 16 - k);
            tick();
            check("fill_wen", fifo_write_en, 1);
            check("fill_data", fifo_data_in, wd[k]);
        end
        req_data = {24'h0, wd[16]};
        #1;
        check("full_gnt", req_gnt, 0);
        check("full_credits", credits, 0);
        tick();
        check("full_wen", fifo_write_en, 0);
        check("full_flag", fifo_full, 1);
        check("full_gnt_hold", req_gnt, 0);
        check("full_ovf", err_ovf, 0);

        req_valid = 4'b0000; fifo_read_en = 1'b1;
        for (int k = 0; k < 16; k++) tick();
        fifo_read_en = 1'b0;
        check("drain_credits", credits, 16);
        check("drain_count", got.size(), 16);
        for (int k = 0; k < 16 && k < got.size(); k++) check("drain_order", got[k], wd[k]);
        check("drain_udf", err_udf, 0);
        got.delete();

        rst = 1'b0; tick(); rst = 1'b1;
        req_valid = 4'b1111; req_data = 32'h44332211;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("rr4_gnt", req_gnt, 4'b0001 << (k % 4));
            tick();
            check("rr4_data", fifo_data_in, 8'h11 * ((k % 4) + 1));
        end
        check("rr4_credits", credits, 8);
        req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr2_gnt", req_gnt, (k % 2 == 0) ? 4'b0010 : 4'b1000);
            tick();
        end
        check("rr2_credits", credits, 4);

        req_valid = 4'b0001;
        tick(); tick(); tick();
        check("cr_one", credits, 1);
        fifo_read_en = 1'b1;
        #1;
        check("cr_both_gnt", req_gnt, 4'b0001);
        tick();
        fifo_read_en = 1'b0;
        check("cr_both_credits", credits, 1);
        tick();
        check("cr_zero", credits, 0);
        #1;
        check("cr_zero_gnt", req_gnt, 0);
        req_valid = 4'b0000; fifo_read_en = 1'b1;
        tick();
        fifo_read_en = 1'b0;
        check("cr_ret_credits", credits, 1);
        req_valid = 4'b0001;
        #1;
        check("cr_ret_gnt", req_gnt, 4'b0001);
        tick();
        check("cr_ret_wen", fifo_write_en, 1);
        check("cr_ret_zero", credits, 0);

        req_valid = 4'b0000; fifo_read_en = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        fifo_read_en = 1'b0;
        check("udf_pre_credits", credits, 16);
        check("udf_pre_flag", err_udf, 0);
        ovr_nempty = 1'b1; fifo_read_en = 1'b1;
        tick();
        ovr_nempty = 1'b0; fifo_read_en = 1'b0;
        check("udf_flag", err_udf, 1);
        check("udf_credits", credits, 16);
        tick(); tick();
        check("udf_sticky", err_udf, 1);

        req_valid = 4'b1111;
        #1;
        check("mid_gnt", req_gnt, 4'b0010);
        tick();
        check("mid_wen", fifo_write_en, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_gnt", req_gnt, 0);
        tick();
        check("mid_rst_wen", fifo_write_en, 0);
        check("mid_rst_credits", credits, 16);
        check("mid_rst_udf", err_udf, 0);
        rst = 1'b1;
        #1;
        check("mid_first_gnt", req_gnt, 4'b0001);
        tick();
        check("mid_first_wen", fifo_write_en, 1);
        check("mid_first_data", fifo_data_in, 8'h11);
        check("ovf_pre", err_ovf, 0);

        req_valid = 4'b0000; ovr_full = 1'b1;
        tick();
        ovr_full = 1'b0;
        check("ovf_flag", err_ovf, 1);
        tick();
        check("ovf_sticky", err_ovf, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one syn_fifo write port between N_REQ producers.
- Accepts words over per-requester valid/grant handshakes and issues one registered FIFO write per cycle.
- Keeps a local credit count of free FIFO entries, so it never writes into a full FIFO.
- Sits directly in front of syn_fifo (write_en/data_in/full) and observes the consumer's read_en/empty to return credits.

Parameters:
N_REQ, 4, number of requesters (≥2)
DATA_W, 8, word width; must equal syn_fifo data width
DEPTH, 16, syn_fifo depth; initial credit count
CNT_W, $clog2(DEPTH+1), credit counter width (derived)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-low (rst==0 resets on clk edge)
req_valid  in  N_REQ  requester i has a word ready
req_data  in  N_REQ*DATA_W  packed words; requester i at [i*DATA_W +: DATA_W]
req_gnt  out  N_REQ  one-hot; word from requester i accepted this cycle
fifo_write_en  out  1  to syn_fifo write_en, registered
fifo_data_in  out  DATA_W  to syn_fifo data_in, registered
fifo_full  in  1  from syn_fifo full; error check only
fifo_read_en  in  1  consumer read_en, observed
fifo_empty  in  1  from syn_fifo empty
credits  out  CNT_W  free entries, including in-flight write
err_ovf  out  1  sticky: write issued while fifo_full high
err_udf  out  1  sticky: read observed while credits==DEPTH

Behaviour:
- Reset (rst low at an edge):
  - fifo_write_en=0, fifo_data_in=0, credits=DEPTH, rr_ptr=0, err_ovf=0, err_udf=0.
  - req_gnt is forced to 0 while rst is low.
- rd_fire = fifo_read_en && !fifo_empty.
- can_accept = (credits != 0).
- Arbitration (combinational, from registered rr_ptr and credits):
  - Scan requesters starting at rr_ptr, wrapping modulo N_REQ.
  - The first i with req_valid[i] is the winner w.
  - accept = can_accept && any req_valid.
  - req_gnt[w] = accept; all other bits are 0.
- Handshake rules:
  - A transfer occurs when req_gnt[i]=1.
  - A requester holds valid and data until granted, and may drop valid only after a grant.
- On an accept edge:
  - fifo_write_en<=1 and fifo_data_in<=data[w].
  - rr_ptr<=(w+1) mod N_REQ.
- On a no-accept edge:
  - fifo_write_en<=0; fifo_data_in holds its value; rr_ptr holds.
- Latency: a grant in cycle k gives fifo_write_en high in cycle k+1, and syn_fifo captures the word at the end of cycle k+1. Throughput is 1 word/cycle.
- Credits (accept and rd_fire are each 1 bit):
  - credits<=credits - accept + rd_fire.
  - Simultaneous accept and rd_fire leaves credits unchanged.
  - A credit is consumed at grant, so the registered write pipeline cannot overflow.
- Boundary conditions:
  - credits==0: no grant; requesters stall; fifo_write_en deasserts the next cycle.
  - rd_fire while credits==0 makes credits=1, and a grant is possible the next cycle.
  - rd_fire while credits==DEPTH: credits stays at DEPTH and err_udf<=1.
- Errors:
  - err_ovf<=1 if fifo_write_en && fifo_full at an edge.
  - Both error flags are sticky and cleared only by reset.
- Reset mid-operation:
  - A pending fifo_write_en is dropped; the next cycle it is 0.
  - The syn_fifo must share the same reset so that occupancy and credits stay consistent.

Decomposition:
- Package fifo_arb_pkg holds:
  - default constants N_REQ_DEF=4, DATA_W_DEF=8, DEPTH_DEF=16;
  - function clog2_plus1 for CNT_W.
- Sub-module rr_pick (natural split): pure combinational round-robin picker.
  - Inputs: req[N_REQ], ptr.
  - Outputs: one-hot gnt, index w, any.
  - Reusable for the read-side scheduler.
- The top level holds the credit counter, rr_ptr, output registers and error flags.

Test Plan:
- Reset: hold rst=0 for 2 edges with all req_valid=1 → req_gnt=0, fifo_write_en=0, credits=16, err_ovf=err_udf=0.
- Fill, no reads: requester 0 offers 17 random words back-to-back → 16 grants on consecutive cycles, credits reaches 0, 17th word held ungranted, fifo_full=1, err_ovf stays 0; FIFO later drains the 16 words in order.
- Round-robin: req_valid=4'b1111 for 8 cycles with ample credits → grant order 0,1,2,3,0,1,2,3; then req_valid=4'b1010 → 1,3,1,3.
- Credit return: with credits=1, grant and rd_fire in the same cycle → credits stays 1. At credits=0, rd_fire with no requests → credits=1, and the next request is granted the following cycle.
- Underflow error: at credits=16, drive fifo_read_en=1 and fifo_empty=0 for one cycle → err_udf=1 and stays 1 until rst=0; credits stays 16.
- Reset mid-stream: rst=0 in the cycle after a grant (fifo_write_en=1) → next cycle fifo_write_en=0, credits=16, rr_ptr=0; the first grant after reset goes to requester 0 when all are valid.
